// File: rtl/gcd_pkg.sv
// gcd_pkg
//   Shared types and helpers for the GCD job sequencer front end.
//   - gcd_state_t   : sequencer FSM states
//   - GCD_W         : default operand/result width
//   - wd_cnt_width  : width of a counter that must hold the value TIMEOUT
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT    = 3'd4
  } gcd_state_t;

  // clog2(timeout+1), never less than 1 so a disabled watchdog (0) still
  // gets a legal one-bit counter.
  function automatic int wd_cnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// gcd_pair_fifo
//   Synchronous FIFO holding operand pairs for the sequencer.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (pointers/count)
//     i_push       : write i_data (ignored when full)
//     i_pop        : drop the head entry (ignored when empty)
//     i_data       : {a, b} pair to store
//     o_data       : head entry (valid when o_count != 0)
//     o_count      : number of stored entries, 0..DEPTH
//     o_full       : o_count == DEPTH
module gcd_pair_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_data,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer
//   Front end for the subtractive GCD core. Buffers operand pairs, loads
//   each onto the core's serial interface (start+A, then B), waits for
//   done, and returns the result on a valid/ready stream. Pairs with a
//   zero operand are answered directly (the core never terminates on
//   them); a watchdog turns a hung core into an error result.
//
//   Handshakes: a beat transfers on a rising clk edge where valid and ready
//   are both 1. The source holds its data stable while valid is high and
//   ready is low; valid does not depend on ready.
//
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     in_valid/in_ready       : operand pair stream (in_a, in_b)
//     out_valid/out_ready     : result stream (out_gcd, out_err)
//     busy                    : job in flight or pairs buffered
//     core_start, core_data   : registered load interface to the core
//     core_done, core_result  : core completion and final A register
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         busy,
  output logic         core_start,
  output logic [W-1:0] core_data,
  input  logic         core_done,
  input  logic [W-1:0] core_result
);

  localparam int CW = wd_cnt_width(TIMEOUT);

  gcd_state_t            r_state;
  gcd_state_t            w_state_next;
  logic                  r_live;
  logic [W-1:0]          r_job_b;
  logic [CW-1:0]         r_wd_cnt;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_timeout;
  logic                  r_core_start;
  logic [W-1:0]          r_core_data;
  logic [W-1:0]          r_out_gcd;
  logic                  r_out_err;

  logic                  w_push;
  logic                  w_pop;
  logic [2*W-1:0]        w_head;
  logic [W-1:0]          w_head_a;
  logic [W-1:0]          w_head_b;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_zero_op;

  // r_live keeps in_ready low until the first clock after reset release.
  assign in_ready  = r_live && !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_empty   = (w_count == '0);
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_head_a  = w_head[2*W-1:W];
  assign w_head_b  = w_head[W-1:0];
  assign w_zero_op = (w_head_a == '0) || (w_head_b == '0);

  gcd_pair_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({in_a, in_b}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Watchdog fires on the cycle its count would reach TIMEOUT, so out_valid
  // rises exactly TIMEOUT cycles after WAIT is entered.
  assign w_cnt_inc = r_wd_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next = w_zero_op ? ST_OUT : ST_LOAD_A;
        end
      end
      ST_LOAD_A: w_state_next = ST_LOAD_B;
      ST_LOAD_B: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (core_done || w_timeout) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Job datapath and registered outputs. A goes straight from the FIFO head
  // onto core_data at dispatch, so only B needs a job register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live       <= 1'b0;
      r_job_b      <= '0;
      r_wd_cnt     <= '0;
      r_core_start <= 1'b0;
      r_core_data  <= '0;
      r_out_gcd    <= '0;
      r_out_err    <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_core_start <= (w_state_next == ST_LOAD_A);
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_zero_op) begin
              r_out_gcd <= w_head_a | w_head_b;
              r_out_err <= 1'b0;
            end else begin
              r_core_data <= w_head_a;
              r_job_b     <= w_head_b;
            end
          end
        end
        ST_LOAD_A: r_core_data <= r_job_b;
        ST_LOAD_B: r_wd_cnt <= '0;
        ST_WAIT: begin
          // done has priority over a watchdog expiry in the same cycle
          if (core_done) begin
            r_out_gcd <= core_result;
            r_out_err <= 1'b0;
          end else if (w_timeout) begin
            r_out_gcd <= '0;
            r_out_err <= 1'b1;
          end else begin
            r_wd_cnt <= w_cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid  = (r_state == ST_OUT);
  assign out_gcd    = r_out_gcd;
  assign out_err    = r_out_err;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign core_start = r_core_start;
  assign core_data  = r_core_data;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer
//   Self-checking bench for gcd_job_sequencer (W=16, DEPTH=4, TIMEOUT=20).
//   A behavioural core answers each load with the Euclidean GCD after a
//   random delay (or never, for jobs marked hang). Every accepted pair
//   gets an expected result; the monitor compares every out_valid cycle.
module tb_gcd_job_sequencer;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_done;
  logic [W-1:0] core_result;

  always #5 clk = ~clk;

  gcd_job_sequencer #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .busy        (busy),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result)
  );

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           hang;
  } pair_t;

  pair_t      pair_q[$];   // accepted pairs, oldest first
  logic [W:0] exp_q[$];    // expected {err, gcd} per accepted pair

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int valid_rise_cyc = 0;
  int accept_cyc = 0;
  int n_starts = 0;
  int n_accepted = 0;
  int n_results = 0;
  logic [W-1:0] last_gcd = '0;
  logic         last_err = 1'b0;
  logic [W-1:0] last_load_a = '0;
  logic [W-1:0] last_load_b = '0;
  bit hang_next = 1'b0;
  bit rand_ready_en = 1'b0;
  bit noise_en = 1'b1;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [W:0] expected_result(input pair_t p);
    if (p.hang && p.a != 0 && p.b != 0) begin
      return {1'b1, {W{1'b0}}};
    end
    return {1'b0, ref_gcd(p.a, p.b)};
  endfunction

  // ---------------- monitor / compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (core_start) begin
          n_starts++;
          start_cyc = cyc;
        end
        if (out_valid && !prev_ov) begin
          valid_rise_cyc = cyc;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("out_unexpected", 32'(out_valid), 32'd0);
          end else begin
            chk("out_result", 32'({out_err, out_gcd}), 32'(exp_q[0]));
            if (out_ready) begin
              last_gcd = out_gcd;
              last_err = out_err;
              void'(exp_q.pop_front());
              void'(pair_q.pop_front());
              n_results++;
            end
          end
        end
        if (in_valid && in_ready) begin
          pair_t p;
          p.a = in_a;
          p.b = in_b;
          p.hang = hang_next;
          pair_q.push_back(p);
          exp_q.push_back(expected_result(p));
          n_accepted++;
          accept_cyc = cyc;
        end
        prev_ov = out_valid;
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  // ---------------- behavioural core ----------------
  initial begin
    int           phase;
    int           delay;
    bit           job_hang;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    logic [W-1:0] res;
    phase = 0;
    delay = 0;
    job_hang = 1'b0;
    ca = '0;
    cb = '0;
    res = '0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        core_done = 1'b0;
      end else begin
        core_done = 1'b0;
        core_result = W'($urandom);
        if (phase == 1) begin
          chk("core_start_width", 32'(core_start), 32'd0);
          cb = core_data;
          last_load_b = cb;
          if (pair_q.size() > 0) begin
            chk("core_load_b", 32'(cb), 32'(pair_q[0].b));
            job_hang = pair_q[0].hang;
          end
          res = ref_gcd(ca, cb);
          delay = $urandom_range(0, 6);
          phase = 2;
        end else if (core_start) begin
          ca = core_data;
          last_load_a = ca;
          chk("core_job_present", 32'(pair_q.size() > 0), 32'd1);
          if (pair_q.size() > 0) begin
            chk("core_load_a", 32'(ca), 32'(pair_q[0].a));
            chk("core_not_bypass", 32'(pair_q[0].a != 0 && pair_q[0].b != 0), 32'd1);
          end
          // a stray done during LOAD_A must be ignored
          if (noise_en) core_done = ($urandom_range(0, 1) == 1);
          phase = 1;
        end else if (phase == 2) begin
          if (!job_hang) begin
            if (delay == 0) begin
              core_done = 1'b1;
              core_result = res;
              phase = 0;
            end else begin
              delay--;
            end
          end
        end else if (noise_en) begin
          core_done = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Random backpressure, only while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+1.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("push_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while ((busy || out_valid || exp_q.size() != 0) && g < budget) begin
      step(1);
      g++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gcd", 32'(out_gcd), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_data", 32'(core_data), 32'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return W'($urandom);
    return W'($urandom_range(1, 400));
  endfunction

  // Hard stop so the bench can never hang.
  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  logic [W-1:0] za [3] = '{16'd0, 16'd48, 16'd0};
  logic [W-1:0] zb [3] = '{16'd35, 16'd0, 16'd0};
  logic [W-1:0] zg [3] = '{16'd35, 16'd48, 16'd0};

  initial begin
    int s0;
    int s1;
    int acc0;
    int r0;
    int g;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;

    // Reset state
    step(3);
    chk_reset_outputs();
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_low", 32'(in_ready), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    step(1);
    chk("release_in_ready_high", 32'(in_ready), 32'd1);

    // 1: basic core job
    s0 = n_starts;
    r0 = n_results;
    push_pair(16'd143, 16'd78);
    wait_idle(100);
    chk("t1_one_start", 32'(n_starts - s0), 32'd1);
    chk("t1_load_a", 32'(last_load_a), 32'd143);
    chk("t1_load_b", 32'(last_load_b), 32'd78);
    chk("t1_gcd", 32'(last_gcd), 32'd13);
    chk("t1_err", 32'(last_err), 32'd0);
    chk("t1_one_beat", 32'(n_results - r0), 32'd1);

    // 2: zero-operand bypass
    s0 = n_starts;
    for (int i = 0; i < 3; i++) begin
      push_pair(za[i], zb[i]);
      wait_idle(50);
      chk("t2_bypass_latency", 32'(valid_rise_cyc - accept_cyc), 32'd2);
      chk("t2_bypass_gcd", 32'(last_gcd), 32'(zg[i]));
      chk("t2_bypass_err", 32'(last_err), 32'd0);
    end
    chk("t2_core_untouched", 32'(n_starts), 32'(s0));

    // 3: FIFO fill under backpressure
    out_ready = 1'b0;
    acc0 = n_accepted;
    r0 = n_results;
    for (int i = 0; i < 5; i++) begin
      push_pair(W'($urandom_range(1, 500)), W'($urandom_range(1, 500)));
    end
    in_valid = 1'b1;
    in_a = 16'd210;
    in_b = 16'd330;
    step(20);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    chk("t3_accepted", 32'(n_accepted - acc0), 32'd5);
    chk("t3_result_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    g = 0;
    while (n_accepted - acc0 < 6 && g < 200) begin
      step(1);
      g++;
    end
    in_valid = 1'b0;
    chk("t3_sixth_accepted", 32'(n_accepted - acc0), 32'd6);
    wait_idle(300);
    chk("t3_all_results", 32'(n_results - r0), 32'd6);

    // 4: watchdog
    hang_next = 1'b1;
    push_pair(16'd120, 16'd84);
    hang_next = 1'b0;
    wait_idle(200);
    chk("t4_timeout_latency", 32'(valid_rise_cyc - start_cyc), 32'(TIMEOUT + 2));
    chk("t4_timeout_err", 32'(last_err), 32'd1);
    chk("t4_timeout_gcd", 32'(last_gcd), 32'd0);
    push_pair(16'd120, 16'd84);
    wait_idle(100);
    chk("t4_recover_err", 32'(last_err), 32'd0);
    chk("t4_recover_gcd", 32'(last_gcd), 32'd12);

    // 5: reset during WAIT with two pairs queued
    s0 = n_starts;
    hang_next = 1'b1;
    push_pair(16'd77, 16'd21);
    push_pair(16'd50, 16'd15);
    push_pair(16'd9, 16'd6);
    hang_next = 1'b0;
    g = 0;
    while (n_starts == s0 && g < 50) begin
      step(1);
      g++;
    end
    chk("t5_started", 32'(n_starts - s0), 32'd1);
    step(4);
    chk("t5_queued_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    pair_q.delete();
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    #1;
    chk("t5_release_busy", 32'(busy), 32'd0);
    chk("t5_release_in_ready", 32'(in_ready), 32'd0);
    step(1);
    chk("t5_in_ready_back", 32'(in_ready), 32'd1);
    s1 = n_starts;
    step(20);
    chk("t5_no_stale_start", 32'(n_starts), 32'(s1));
    chk("t5_no_stale_valid", 32'(out_valid), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6: result held while a new pair is buffered
    out_ready = 1'b0;
    push_pair(16'd91, 16'd35);
    g = 0;
    while (!out_valid && g < 50) begin
      step(1);
      g++;
    end
    s1 = n_starts;
    push_pair(16'd40, 16'd64);
    step(10);
    chk("t6_hold_valid", 32'(out_valid), 32'd1);
    chk("t6_hold_gcd", 32'(out_gcd), 32'd7);
    chk("t6_hold_err", 32'(out_err), 32'd0);
    chk("t6_no_dispatch", 32'(n_starts), 32'(s1));
    out_ready = 1'b1;
    wait_idle(100);
    chk("t6_dispatched_after", 32'(n_starts), 32'(s1 + 1));
    chk("t6_second_gcd", 32'(last_gcd), 32'd8);

    // Random traffic with random backpressure and occasional hung jobs
    r0 = n_results;
    acc0 = n_accepted;
    rand_ready_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      hang_next = ($urandom_range(0, 9) == 0);
      push_pair(pick_operand(), pick_operand());
      hang_next = 1'b0;
      step($urandom_range(0, 3));
    end
    rand_ready_en = 1'b0;
    step(1);
    out_ready = 1'b1;
    wait_idle(2000);
    chk("rand_results", 32'(n_results - r0), 32'(n_accepted - acc0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
Front-end stage that feeds the subtractive GCD core (datapath + controller). It accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, and sequences each pair onto the core's serial load interface: start, then A, then B. It waits for done, captures the result, and presents it on a valid/ready output stream. It also short-circuits zero operands, which the core cannot terminate on, and guards against a hung core with a watchdog.

Parameters:
W, 16, operand/result width
DEPTH, 4, input FIFO depth in pairs (power of 2, >=2)
TIMEOUT, 1023, max cycles in WAIT before error; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_a  in  W  operand A
in_b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_gcd  out  W  GCD result
out_err  out  1  result flagged as timed out, qualified by out_valid
busy  out  1  state != IDLE or FIFO non-empty
core_start  out  1  start pulse to the core controller
core_data  out  W  serial operand bus to the core data_in
core_done  in  1  core completion
core_result  in  W  core A register (final GCD)

Behaviour:
- Reset (async, rst_n=0): all state clears immediately.
  - FIFO pointers and count are set to 0; state goes to IDLE.
  - in_ready=0 while rst_n is low, then 1 from the first clock after release.
  - out_valid=0, out_gcd=0, out_err=0, busy=0, core_start=0, core_data=0.
- FIFO: a push occurs when in_valid&in_ready; a pop occurs on IDLE dispatch.
  - Simultaneous push and pop when full: the push is refused, because in_ready is computed from the registered count.
  - Simultaneous push and pop when empty: no pop; the pushed pair is visible the next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, OUT.
- IDLE: if the FIFO is non-empty, pop the head.
  - If head a==0 or b==0: out_gcd = a|b (0 if both are 0), out_err=0, go to OUT. The core is not touched.
  - Otherwise latch a and b into the job register and go to LOAD_A.
- LOAD_A (1 cycle): core_start=1, core_data=A. Go to LOAD_B.
- LOAD_B (1 cycle): core_start=0, core_data=B. Go to WAIT; clear the watchdog counter.
- WAIT:
  - core_data holds B.
  - On core_done=1: out_gcd<=core_result, out_err<=0, go to OUT.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (and TIMEOUT!=0): out_gcd<=0, out_err<=1, go to OUT.
  - core_done seen in the same cycle as the counter reaching TIMEOUT: done wins, err=0.
- OUT: out_valid=1; out_gcd and out_err are held stable until out_ready.
  - On out_valid&out_ready go to IDLE.
  - No skid: minimum job spacing is one cycle of IDLE.
- Latency, nonzero pair from FIFO head to out_valid: 1 (IDLE) + 2 (load) + core cycles + 1.
- Latency, zero bypass: FIFO head to out_valid is 1 cycle.
- core_done outside WAIT is ignored.
- Reset mid-operation aborts the job. The in-flight result is lost and buffered pairs are discarded; the core is expected to share rst_n/start gating.
- core_start is a registered output and is glitch-free.

Decomposition:
- Shared package gcd_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, WAIT, OUT)
  - default W
  - TIMEOUT counter width function: clog2(TIMEOUT+1)
- One natural sub-module: gcd_pair_fifo.
  - Synchronous, 2W-wide, DEPTH entries, with count.
  - The same async active-low reset.
- The FSM, bypass and watchdog remain in gcd_job_sequencer.

Test Plan:
1. Push (143,78), behavioural core model, out_ready=1 -> core_start pulse with core_data=143, next cycle 78; out_gcd=13, out_err=0, exactly one out_valid beat.
2. Push (0,35), then (48,0), then (0,0) -> the core is never started; out_gcd 35, then 48, then 0, each 1 cycle after dispatch.
3. out_ready=0, push 6 pairs back-to-back with DEPTH=4 -> in_ready drops after 4 accepted plus 1 dispatched; release out_ready -> results emerge in order; no pair is lost or duplicated.
4. Core model never asserts done, TIMEOUT=20 -> out_valid with out_err=1, out_gcd=0, exactly 20 cycles after entering WAIT; the next job proceeds normally.
5. Assert rst_n=0 during WAIT with 2 pairs queued -> all outputs are 0 immediately; after release busy=0 and no stale result appears.
6. Hold the result with out_ready=0 for 10 cycles while pushing a new pair -> out_gcd/out_err remain stable; the new pair is accepted into the FIFO and is dispatched only after the handshake.
